if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and talks to a variable-latency instruction memory through a request/response handshake.
- Presents {PC+4, instruction, valid} to the IF/ID register.
- Absorbs hazard stalls with a one-entry skid buffer and handles branch/jump redirects, including squashing an in-flight fetch.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (bits [1:0] must be 0).
- NOP_INST, 32'h00000000, instruction word driven on inst_out while inst_valid=0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hazard unit: IF/ID must not load this cycle
- redirect  in  1  taken branch/jump; highest priority
- redirect_pc  in  16  new PC; bits [1:0] ignored, treated as 0
- imem_req  out  1  fetch request valid
- imem_addr  out  16  fetch byte address
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response instruction
- pcp_out  out  16  PC+4 of presented instruction (to IF/ID PC+4 input)
- inst_out  out  32  presented instruction (to IF/ID instruction input)
- inst_valid  out  1  pcp_out/inst_out hold a real instruction

Behaviour:
- Reset (async):
  - pc=RESET_PC; state=S_REQ.
  - inst_valid=0, inst_out=NOP_INST, pcp_out=0.
  - Skid buffer invalid; squash flag=0.
  - imem_req=0 while rst is high.
- Consume: a rising edge with inst_valid=1 and stall=0.
- Registers:
  - Output register: inst_out, pcp_out, inst_valid.
  - Skid register: data, pcp, valid.
  - At most one memory request outstanding.
- States: S_REQ, S_WAIT, S_FULL, S_DRAIN.
- Outputs per state:
  - imem_req = (state==S_REQ) && !redirect.
  - imem_addr = pc in every state.
- S_REQ:
  - On imem_req && imem_ready: req_pcp <= pc+4, pc <= pc+4, go S_WAIT.
  - Otherwise stay.
- S_WAIT, on imem_rvalid:
  - Output register empty or consumed this edge: load it ({imem_rdata, req_pcp}, inst_valid=1), go S_REQ.
  - Otherwise: load skid, go S_FULL.
- S_FULL:
  - No requests issued.
  - On consume: skid moves to output register, skid invalid, go S_REQ.
- S_DRAIN:
  - Waits for the squashed response. On imem_rvalid: discard data, go S_REQ.
- Consume with no replacement available: inst_valid<=0, inst_out<=NOP_INST.
- Redirect (overrides stall and every other event on the same edge):
  - pc <= {redirect_pc[15:2],2'b00}.
  - inst_valid <= 0, inst_out <= NOP_INST; skid invalidated.
  - From S_WAIT without rvalid: go S_DRAIN.
  - From S_WAIT with rvalid on the same edge: response discarded, go S_REQ.
  - From S_REQ, S_FULL, or S_DRAIN with rvalid: go S_REQ.
  - From S_DRAIN without rvalid: stay S_DRAIN, pc updated.
- imem_rvalid in S_REQ or S_FULL is ignored (protocol violation).
- Arithmetic: PC+4 is 16-bit modulo; 16'hFFFC+4 = 16'h0000.
- Latency and throughput:
  - Request accepted at edge n, rvalid in the cycle after: inst_valid=1 after edge n+1.
  - Next request issued in cycle n+1, giving a peak of one instruction per 2 cycles with zero-wait memory.
- Ordering: no instruction is lost, duplicated, or reordered across stalls. Only redirect drops instructions.
- Reset mid-operation: all state is cleared immediately. A response arriving after reset release while in S_REQ is ignored.

Test Plan:
- Reset: RESET_PC=16'h0000; hold rst then release -> imem_req=1, imem_addr=16'h0000, inst_valid=0, inst_out=32'h0, pcp_out=16'h0.
- Zero-wait memory (imem_ready=1, rvalid the cycle after acceptance, rdata=32'hA5000000|addr), stall=0:
  - inst_valid every other cycle.
  - Sequence (pcp_out, inst_out) = (0004, A5000000), (0008, A5000004), (000C, A5000008).
- Stall=1 for 5 cycles after the first instruction is presented:
  - Output holds (0004, A5000000).
  - Second response lands in skid; imem_req=0 in S_FULL.
  - After release, consumed in order (0004, 0008, 000C); no gaps or duplicates.
- Memory latency 3 cycles, redirect=1 with redirect_pc=16'h0103 while in S_WAIT:
  - inst_valid=0 immediately; stale response discarded (S_DRAIN).
  - Next imem_addr=16'h0100; presented pcp_out=16'h0104.
- Redirect coincident with imem_rvalid, and redirect while stalled with skid full:
  - Both buffers cleared; no stale instruction ever presented.
  - Next request goes to the redirect address.
- Wrap: redirect_pc=16'hFFFC -> fetch address FFFC presented with pcp_out=16'h0000; next imem_addr=16'h0000.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, one outstanding imem request,
// one-entry skid buffer in front of IF/ID, redirect with in-flight squash.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [15:0]           redirect_pc,
    if_fetch_unit_if.master       imem,
    output logic [15:0]           pcp_out,
    output logic [31:0]           inst_out,
    output logic                  inst_valid
);

    localparam int unsigned PC_W   = 16;
    localparam int unsigned INST_W = 32;
    localparam logic [PC_W-1:0] PC_STEP       = PC_W'(4);
    localparam logic [PC_W-1:0] PC_ALIGN_MASK = PC_W'(16'hFFFC);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DRAIN} state_t;

    state_t              state, state_n;
    logic [PC_W-1:0]     pc, pc_n;
    logic [PC_W-1:0]     req_pcp, req_pcp_n;
    logic [PC_W-1:0]     out_pcp_n;
    logic [INST_W-1:0]   out_inst_n;
    logic                out_valid_n;
    logic [INST_W-1:0]   skid_data, skid_data_n;
    logic [PC_W-1:0]     skid_pcp, skid_pcp_n;
    logic                skid_valid, skid_valid_n;
    logic                consume;

    // IF/ID takes the presented instruction on this edge
    assign consume = inst_valid && !stall;

    assign imem.imem_req  = (state == S_REQ) && !redirect && !rst;
    assign imem.imem_addr = pc;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            req_pcp    <= '0;
            pcp_out    <= '0;
            inst_out   <= NOP_INST;
            inst_valid <= 1'b0;
            skid_data  <= NOP_INST;
            skid_pcp   <= '0;
            skid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_pcp    <= req_pcp_n;
            pcp_out    <= out_pcp_n;
            inst_out   <= out_inst_n;
            inst_valid <= out_valid_n;
            skid_data  <= skid_data_n;
            skid_pcp   <= skid_pcp_n;
            skid_valid <= skid_valid_n;
        end
    end

    // Next-state and datapath steering; redirect overrides every other event
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_pcp_n    = req_pcp;
        out_pcp_n    = pcp_out;
        out_inst_n   = inst_out;
        out_valid_n  = inst_valid;
        skid_data_n  = skid_data;
        skid_pcp_n   = skid_pcp;
        skid_valid_n = skid_valid;

        if (redirect) begin
            pc_n         = redirect_pc & PC_ALIGN_MASK;
            out_valid_n  = 1'b0;
            out_inst_n   = NOP_INST;
            skid_valid_n = 1'b0;
            case (state)
                S_WAIT:  state_n = imem.imem_rvalid ? S_REQ : S_DRAIN;
                S_DRAIN: state_n = imem.imem_rvalid ? S_REQ : S_DRAIN;
                default: state_n = S_REQ;
            endcase
        end else begin
            if (consume) begin
                out_valid_n = 1'b0;
                out_inst_n  = NOP_INST;
            end
            case (state)
                S_REQ: begin
                    if (imem.imem_ready) begin
                        pc_n      = pc + PC_STEP;
                        req_pcp_n = pc + PC_STEP;
                        state_n   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (!inst_valid || consume) begin
                            out_inst_n  = imem.imem_rdata;
                            out_pcp_n   = req_pcp;
                            out_valid_n = 1'b1;
                            state_n     = S_REQ;
                        end else begin
                            skid_data_n  = imem.imem_rdata;
                            skid_pcp_n   = req_pcp;
                            skid_valid_n = 1'b1;
                            state_n      = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    // Output is necessarily valid here; skid refills it on consume
                    if (consume) begin
                        out_inst_n   = skid_data;
                        out_pcp_n    = skid_pcp;
                        out_valid_n  = 1'b1;
                        skid_valid_n = 1'b0;
                        state_n      = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem.imem_rvalid) state_n = S_REQ;
                end
                default: state_n = S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic, checked
// against a program-order scoreboard fed from reset/redirect targets.
module tb_if_fetch_unit;

    typedef struct packed {
        logic [15:0] pcp;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pcp_out;
    logic [31:0] inst_out;
    logic        inst_valid;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC (16'h0000),
        .NOP_INST (32'h00000000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
        .pcp_out     (pcp_out),
        .inst_out    (inst_out),
        .inst_valid  (inst_valid)
    );

    int          checks;
    int          failures;
    int          consumed;
    exp_t        sb[$];
    logic [15:0] push_pc;

    // memory model state
    logic        mem_busy;
    logic [15:0] mem_addr;
    int          mem_wait;
    int          fixed_lat;
    int          ready_pct;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Apply this cycle's inputs (called right after a falling edge)
    task automatic drive(input logic st, input logic rd, input logic [15:0] rpc);
        exp_t e;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (rd) begin
            sb.delete();
            push_pc = rpc & 16'hFFFC;
        end
        while (sb.size() < 8) begin
            e.pcp  = push_pc + 16'd4;
            e.inst = 32'hA5000000 | 32'(push_pc);
            sb.push_back(e);
            push_pc = push_pc + 16'd4;
        end
        bus.imem_rvalid = 1'b0;
        if (mem_busy) begin
            mem_wait--;
            if (mem_wait == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = 32'hA5000000 | 32'(mem_addr);
                mem_busy        = 1'b0;
            end
        end
        bus.imem_ready = ($urandom_range(99) < ready_pct);
        #2;
        if (bus.imem_req && bus.imem_ready) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_addr;
            mem_wait = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(3, 1));
        end
    endtask

    task automatic step(input logic st, input logic rd, input logic [15:0] rpc);
        @(negedge clk);
        drive(st, rd, rpc);
    endtask

    // Async reset for a few cycles; returns in cycle 0 after release, inputs applied
    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_ready  = 1'b1;
        mem_busy        = 1'b0;
        sb.delete();
        push_pc = 16'h0000;
        #2;
        check("req_low_in_reset", 32'(bus.imem_req), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);
    endtask

    // Scoreboard monitor: every consume must match next program-order entry
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (inst_valid && !stall && !redirect) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_underflow: actual=consume required=none");
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_pcp", 32'(pcp_out), 32'(e.pcp));
                        check("sb_inst", inst_out, e.inst);
                        consumed++;
                    end
                end
                if (!inst_valid) check("nop_when_invalid", inst_out, 32'h00000000);
            end
        end
    end

    initial begin
        bit found;
        checks      = 0;
        failures    = 0;
        consumed    = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        mem_busy    = 1'b0;
        mem_addr    = 16'h0;
        mem_wait    = 0;
        fixed_lat   = 1;
        ready_pct   = 100;
        push_pc     = 16'h0000;

        // Reset values and zero-wait streaming
        do_reset();
        check("rst_req", 32'(bus.imem_req), 32'd1);
        check("rst_addr", 32'(bus.imem_addr), 32'h0000);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst_out, 32'h0);
        check("rst_pcp", 32'(pcp_out), 32'h0);
        for (int c = 1; c <= 6; c++) begin
            step(1'b0, 1'b0, 16'h0);
            check("stream_valid_pattern", 32'(inst_valid), (c % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Stall five cycles once the first instruction is presented
        do_reset();
        step(1'b0, 1'b0, 16'h0);
        for (int c = 2; c <= 6; c++) begin
            step(1'b1, 1'b0, 16'h0);
            if (c >= 4) begin
                check("full_req_low", 32'(bus.imem_req), 32'd0);
                check("hold_valid", 32'(inst_valid), 32'd1);
                check("hold_pcp", 32'(pcp_out), 32'h0004);
                check("hold_inst", inst_out, 32'hA5000000);
            end
        end
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 16'h0);

        // Redirect while waiting on a 3-cycle memory
        fixed_lat = 3;
        do_reset();
        step(1'b0, 1'b1, 16'h0103);
        step(1'b0, 1'b0, 16'h0);
        check("drain_valid", 32'(inst_valid), 32'd0);
        check("drain_req", 32'(bus.imem_req), 32'd0);
        check("drain_addr", 32'(bus.imem_addr), 32'h0100);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        check("post_drain_req", 32'(bus.imem_req), 32'd1);
        check("post_drain_addr", 32'(bus.imem_addr), 32'h0100);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step(1'b0, 1'b0, 16'h0);
            if (inst_valid) begin
                found = 1'b1;
                check("redir_pcp", 32'(pcp_out), 32'h0104);
                check("redir_inst", inst_out, 32'hA5000100);
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL redir_timeout: actual=no_valid required=valid_within_20");
        end

        // Redirect on the same edge as the response
        fixed_lat = 1;
        do_reset();
        step(1'b0, 1'b1, 16'h0200);
        step(1'b0, 1'b0, 16'h0);
        check("coinc_valid", 32'(inst_valid), 32'd0);
        check("coinc_req", 32'(bus.imem_req), 32'd1);
        check("coinc_addr", 32'(bus.imem_addr), 32'h0200);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 16'h0);

        // Redirect while stalled with the skid full
        do_reset();
        step(1'b0, 1'b0, 16'h0);
        for (int c = 2; c <= 4; c++) step(1'b1, 1'b0, 16'h0);
        check("skid_full_req", 32'(bus.imem_req), 32'd0);
        step(1'b1, 1'b1, 16'h0300);
        step(1'b0, 1'b0, 16'h0);
        check("skid_redir_valid", 32'(inst_valid), 32'd0);
        check("skid_redir_req", 32'(bus.imem_req), 32'd1);
        check("skid_redir_addr", 32'(bus.imem_addr), 32'h0300);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 16'h0);

        // PC wrap at the top of the address space
        do_reset();
        step(1'b0, 1'b1, 16'hFFFC);
        step(1'b0, 1'b0, 16'h0);
        check("wrap_addr", 32'(bus.imem_addr), 32'hFFFC);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1 & 1'b0, 16'h0);
        check("wrap_valid", 32'(inst_valid), 32'd1);
        check("wrap_pcp", 32'(pcp_out), 32'h0000);
        check("wrap_inst", inst_out, 32'hA500FFFC);
        check("wrap_next_addr", 32'(bus.imem_addr), 32'h0000);

        // Randomized traffic: stalls, variable latency/ready, redirects, resets
        fixed_lat = 0;
        ready_pct = 70;
        consumed  = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(999) < 2) begin
                do_reset();
            end else begin
                step(($urandom_range(99) < 30) ? 1'b1 : 1'b0,
                     ($urandom_range(99) < 3)  ? 1'b1 : 1'b0,
                     16'($urandom));
            end
        end
        checks++;
        if (consumed < 200) begin
            failures++;
            $display("FAIL random_progress: actual=%0d required>=200", consumed);
        end

        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
